led_mode_sequencer: RTL and testbench

- Drives the LED output selector: generates its 2-bit `state` mode code plus its two pattern waveforms.
- A single push-button cycles the mode, and a long press forces the LED off.
- Sits between the board button pin and the LED selector; all three outputs are registered.

---
 rtl/led_mode_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_led_mode_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_sequencer
// Brief    : Push-button LED mode sequencer. A debounced button cycles the
//            2-bit mode code; a long press forces the mode to off. Also
//            generates a blink square wave (pattern1) and a PWM waveform
//            (pattern2).
// Options  : define LED_BREATHE_EN to ramp the PWM duty as a triangle
//            (breathing); otherwise the duty is a fixed 25%.
// Revision : 1.0 - initial release
// ============================================================================
module led_mode_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
  parameter logic [23:0] LONG_PRESS_CYCLES = 24'd1500000,
  parameter logic [23:0] BLINK_HALF        = 24'd6000000,
  parameter int unsigned PWM_BITS          = 8,
  parameter logic [15:0] STEP_CYCLES       = 16'd20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic [1:0] state,
  output logic       pattern1,
  output logic       pattern2
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } fsm_t;

  logic                r_sync1;
  logic                r_sync2;
  logic [15:0]         r_db_cnt;
  logic                r_deb;
  fsm_t                r_fsm;
  fsm_t                w_fsm_nxt;
  logic [1:0]          r_mode;
  logic [1:0]          w_mode_nxt;
  logic [23:0]         r_hold_cnt;
  logic [23:0]         w_hold_nxt;
  logic [23:0]         r_bl_cnt;
  logic                r_pattern1;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_pattern2;
  logic [PWM_BITS-1:0] w_duty;

  assign state    = r_mode;
  assign pattern1 = r_pattern1;
  assign pattern2 = r_pattern2;

  // Two-flop synchronizer bringing the asynchronous button into clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after it has been stable long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_deb    <= 1'b0;
    end else if (r_sync2 != r_deb) begin
      if (r_db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        r_deb    <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  // Press FSM state, mode and hold counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= ST_IDLE;
      r_mode     <= 2'b00;
      r_hold_cnt <= '0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_mode     <= w_mode_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Press FSM next-state: release in HELD advances the mode, timeout forces off
  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_mode_nxt = r_mode;
    w_hold_nxt = r_hold_cnt;
    case (r_fsm)
      ST_IDLE: begin
        if (r_deb) begin
          w_fsm_nxt  = ST_HELD;
          w_hold_nxt = '0;
        end
      end
      ST_HELD: begin
        if (!r_deb) begin
          w_mode_nxt = r_mode + 2'd1;
          w_fsm_nxt  = ST_IDLE;
        end else if (r_hold_cnt == LONG_PRESS_CYCLES - 24'd1) begin
          w_mode_nxt = 2'b00;
          w_fsm_nxt  = ST_LONG;
        end else begin
          w_hold_nxt = r_hold_cnt + 24'd1;
        end
      end
      ST_LONG: begin
        // Release after a long press must not advance the mode
        if (!r_deb) begin
          w_fsm_nxt = ST_IDLE;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  // Blink generator: toggle pattern1 every BLINK_HALF cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bl_cnt   <= '0;
      r_pattern1 <= 1'b0;
    end else if (r_bl_cnt == BLINK_HALF - 24'd1) begin
      r_bl_cnt   <= '0;
      r_pattern1 <= ~r_pattern1;
    end else begin
      r_bl_cnt <= r_bl_cnt + 24'd1;
    end
  end

  // PWM generator: free-running counter compared against the duty value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt  <= '0;
      r_pattern2 <= 1'b0;
    end else begin
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
      r_pattern2 <= (r_pwm_cnt < w_duty);
    end
  end

`ifdef LED_BREATHE_EN
  localparam logic [PWM_BITS-1:0] c_duty_max = '1;

  logic [PWM_BITS-1:0] r_duty;
  logic                r_dir_up;
  logic [15:0]         r_step_cnt;
  logic                r_step_pend;
  logic                w_step_tc;
  logic                w_wrap;

  assign w_step_tc = (r_step_cnt == STEP_CYCLES - 16'd1);
  assign w_wrap    = &r_pwm_cnt;
  assign w_duty    = r_duty;

  // Breathing ramp: steps are requested by the step timer but only applied
  // at a PWM wrap so each PWM period sees a single, stable duty value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt  <= '0;
      r_step_pend <= 1'b0;
      r_duty      <= '0;
      r_dir_up    <= 1'b1;
    end else begin
      r_step_cnt <= w_step_tc ? 16'd0 : r_step_cnt + 16'd1;
      if (w_wrap && r_step_pend) begin
        r_step_pend <= w_step_tc;
        if (r_dir_up) begin
          if (r_duty == c_duty_max) begin
            r_dir_up <= 1'b0;
            r_duty   <= r_duty - 1'b1;
          end else begin
            r_duty <= r_duty + 1'b1;
          end
        end else begin
          if (r_duty == '0) begin
            r_dir_up <= 1'b1;
            r_duty   <= r_duty + 1'b1;
          end else begin
            r_duty <= r_duty - 1'b1;
          end
        end
      end else if (w_step_tc) begin
        r_step_pend <= 1'b1;
      end
    end
  end
`else
  // Fixed quarter-scale duty (25%)
  localparam logic [PWM_BITS-1:0] c_duty_quarter =
    {{(PWM_BITS-1){1'b0}}, 1'b1} << (PWM_BITS-2);

  assign w_duty = c_duty_quarter;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_mode_sequencer
// Brief    : Directed self-checking bench for led_mode_sequencer. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic [1:0] state;
  logic       pattern1;
  logic       pattern2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES  (16'd4),
    .LONG_PRESS_CYCLES(24'd20),
    .BLINK_HALF       (24'd5),
    .PWM_BITS         (4),
    .STEP_CYCLES      (16'd2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .state   (state),
    .pattern1(pattern1),
    .pattern2(pattern2)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset release lands on a falling edge r; cyc(k) then reaches falling edge r+k
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic short_press();
    btn = 1'b1;
    cyc(8);
    btn = 1'b0;
    cyc(10);
  endtask

  task automatic test_reset();
    btn = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
    checks++; if (pattern1 !== 1'b0) begin errors++; $display("FAIL reset_pattern1: got %b expected 0", pattern1); end
    checks++; if (pattern2 !== 1'b0) begin errors++; $display("FAIL reset_pattern2: got %b expected 0", pattern2); end
    cyc(3);
    rst_n = 1'b1;
    // Button held through reset: debounced after release, counts as new press
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL held_after_reset cyc%0d: got %b expected 00", k, state); end
      if (k == 10) btn = 1'b0;
    end
    cyc(1);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL press_after_reset: got %b expected 01", state); end
  endtask

  task automatic test_short_presses();
    logic [1:0] exp_state;
    do_reset();
    exp_state = 2'b00;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL presses_start: got %b expected 00", state); end
    for (int i = 0; i < 4; i++) begin
      btn = 1'b1;
      cyc(8);
      btn = 1'b0;
      cyc(6);
      checks++; if (state !== exp_state) begin errors++; $display("FAIL press%0d_before: got %b expected %b", i, state, exp_state); end
      cyc(1);
      exp_state = exp_state + 2'd1;
      checks++; if (state !== exp_state) begin errors++; $display("FAIL press%0d_after: got %b expected %b", i, state, exp_state); end
      cyc(3);
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 10; i++) begin
      btn = 1'b1;
      cyc(3);
      btn = 1'b0;
      cyc(3);
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL glitch%0d: got %b expected 00", i, state); end
    end
    cyc(10);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL glitch_settle: got %b expected 00", state); end
  endtask

  task automatic test_long_press();
    short_press();
    short_press();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL long_setup: got %b expected 10", state); end
    btn = 1'b1;
    cyc(26);
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL long_before_expiry: got %b expected 10", state); end
    cyc(1);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL long_expiry: got %b expected 00", state); end
    cyc(13);
    btn = 1'b0;
    cyc(15);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL long_release: got %b expected 00", state); end
  endtask

  // Release one cycle before the long-press limit is still a short press
  task automatic test_long_boundary();
    btn = 1'b1;
    cyc(20);
    btn = 1'b0;
    cyc(6);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL boundary_before: got %b expected 00", state); end
    cyc(1);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL boundary_short: got %b expected 01", state); end
    cyc(5);
  endtask

  task automatic test_pattern1();
    logic exp_p1;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      exp_p1 = ((k / 5) % 2) == 1;
      checks++; if (pattern1 !== exp_p1) begin errors++; $display("FAIL pattern1 cyc%0d: got %b expected %b", k, pattern1, exp_p1); end
    end
  endtask

  task automatic test_pattern2();
    logic exp_p2;
    int   highs;
    int   exp_duty;
    do_reset();
`ifdef LED_BREATHE_EN
    // Duty during period m follows a triangle 0..15..0..1
    for (int m = 0; m < 32; m++) begin
      exp_duty = (m <= 15) ? m : ((m <= 30) ? (30 - m) : (m - 30));
      highs = 0;
      for (int j = 1; j <= 16; j++) begin
        cyc(1);
        exp_p2 = (j - 1) < exp_duty;
        highs += int'(pattern2);
        checks++; if (pattern2 !== exp_p2) begin errors++; $display("FAIL breathe p%0d c%0d: got %b expected %b", m, j, pattern2, exp_p2); end
      end
      checks++; if (highs != exp_duty) begin errors++; $display("FAIL breathe_count p%0d: got %0d expected %0d", m, highs, exp_duty); end
    end
`else
    exp_duty = 4;
    highs = 0;
    for (int k = 1; k <= 32; k++) begin
      cyc(1);
      exp_p2 = ((k - 1) % 16) < exp_duty;
      highs += int'(pattern2);
      checks++; if (pattern2 !== exp_p2) begin errors++; $display("FAIL pattern2 cyc%0d: got %b expected %b", k, pattern2, exp_p2); end
      if ((k % 16) == 0) begin
        checks++; if (highs != exp_duty) begin errors++; $display("FAIL pattern2_count cyc%0d: got %0d expected %0d", k, highs, exp_duty); end
        highs = 0;
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_short_presses();
    test_glitch();
    test_long_press();
    test_long_boundary();
    test_pattern1();
    test_pattern2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
